pc_unit: RTL and testbench

//  Fetch-stage program counter with next-PC selection, stall hold, debug run/step gating and halt.

---
 rtl/pc_unit.sv | 130 +++++++++++++
 tb/tb_pc_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC select, stall hold, run/step gating, halt, pending redirect.
// Optional build macro PC_UNIT_ALIGN_CHECK_EN: clear bits [1:0] of redirect targets and flag them sticky.
module pc_unit #(
    parameter int              NB       = 32,
    parameter logic [NB-1:0]   RESET_PC = {NB{1'b0}},
    parameter int              INC      = 4
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_enable,
    input  logic          i_step_mode,
    input  logic          i_step,
    input  logic          i_stall,
    input  logic          i_redirect,
    input  logic [NB-1:0] i_redirect_pc,
    input  logic          i_halt,
    output logic [NB-1:0] o_pc,
    output logic [NB-1:0] o_pc_4,
    output logic [NB-1:0] o_pc_8,
    output logic          o_halted,
    output logic          o_redirect_pending,
    output logic          o_misaligned
);

    localparam logic [NB-1:0] INC_1_W = NB'(INC);
    localparam logic [NB-1:0] INC_2_W = NB'(2 * INC);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [NB-1:0]   pc_r;
    logic [NB-1:0]   pc_nx_s;
    logic            pend_valid_r;
    logic            pend_valid_nx_s;
    logic [NB-1:0]   pend_pc_r;
    logic [NB-1:0]   pend_pc_nx_s;
    logic            misaligned_r;
    logic            mis_set_s;
    logic            adv_s;
    logic [NB-1:0]   tgt_s;
    logic            tgt_mis_s;

    // Redirect target conditioning; buffered targets are stored already conditioned.
    always_comb begin
        tgt_s     = i_redirect_pc;
        tgt_mis_s = 1'b0;
`ifdef PC_UNIT_ALIGN_CHECK_EN
        tgt_mis_s  = |i_redirect_pc[1:0];
        tgt_s[1:0] = 2'b00;
`endif
    end

    // Next-state, next-PC and pending-buffer selection.
    always_comb begin
        state_nx_s      = state_r;
        pc_nx_s         = pc_r;
        pend_valid_nx_s = pend_valid_r;
        pend_pc_nx_s    = pend_pc_r;
        mis_set_s       = 1'b0;
        adv_s           = 1'b0;
        case (state_r)
            ST_RUN: begin
                adv_s = !i_halt && !i_stall && (i_step_mode ? i_step : i_enable);
                if (i_halt) begin
                    state_nx_s      = ST_HALTED;
                    pend_valid_nx_s = 1'b0;
                end else if (adv_s) begin
                    pend_valid_nx_s = 1'b0;
                    if (i_redirect) begin
                        pc_nx_s   = tgt_s;
                        mis_set_s = tgt_mis_s;
                    end else if (pend_valid_r) begin
                        pc_nx_s = pend_pc_r;
                    end else begin
                        pc_nx_s = pc_r + INC_1_W;
                    end
                end else if (i_redirect) begin
                    // Held cycle: keep the newest target for the next advance.
                    pend_valid_nx_s = 1'b1;
                    pend_pc_nx_s    = tgt_s;
                    mis_set_s       = tgt_mis_s;
                end else begin
                    pc_nx_s = pc_r;
                end
            end
            ST_HALTED: begin
                state_nx_s = ST_HALTED;
            end
            default: begin
                state_nx_s = ST_HALTED;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // PC, pending buffer and sticky misaligned flag.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            pc_r         <= RESET_PC;
            pend_valid_r <= 1'b0;
            pend_pc_r    <= {NB{1'b0}};
            misaligned_r <= 1'b0;
        end else begin
            pc_r         <= pc_nx_s;
            pend_valid_r <= pend_valid_nx_s;
            pend_pc_r    <= pend_pc_nx_s;
            misaligned_r <= misaligned_r | mis_set_s;
        end
    end

    assign o_pc               = pc_r;
    assign o_pc_4             = pc_r + INC_1_W;
    assign o_pc_8             = pc_r + INC_2_W;
    assign o_halted           = (state_r == ST_HALTED);
    assign o_redirect_pending = pend_valid_r;
    assign o_misaligned       = misaligned_r;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed per-cycle vectors push expected state; a monitor pops and compares.
module tb_pc_unit;

`ifdef PC_UNIT_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        smode = 1'b0;
    logic        step = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] o_pc, o_pc_4, o_pc_8;
    logic        o_halted, o_pend, o_mis;

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic        pend;
        logic        mis;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    pc_unit #(.NB(32), .RESET_PC(32'h0), .INC(4)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_step_mode(smode),
        .i_step(step), .i_stall(stall), .i_redirect(redir), .i_redirect_pc(rpc),
        .i_halt(halt), .o_pc(o_pc), .o_pc_4(o_pc_4), .o_pc_8(o_pc_8),
        .o_halted(o_halted), .o_redirect_pending(o_pend), .o_misaligned(o_mis)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: rst_n,en,smode,step,stall,redir,rpc,halt -> expected state after the edge.
    task automatic cyc(input logic r, input logic e, input logic sm, input logic st,
                       input logic sl, input logic rd, input logic [31:0] rp, input logic h,
                       input logic [31:0] epc, input logic eh, input logic ep, input logic em,
                       input string nm);
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e; smode = sm; step = st; stall = sl; redir = rd; rpc = rp; halt = h;
        x.pc = epc; x.halted = eh; x.pend = ep; x.mis = em; x.name = nm;
        sb_q.push_back(x);
    endtask

    // Monitor: state is presented every cycle, compared just after the rising edge.
    initial begin
        exp_t x;
        logic [98:0] act, req;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                act = {o_pc, o_pc_4, o_pc_8, o_halted, o_pend, o_mis};
                req = {x.pc, x.pc + 32'd4, x.pc + 32'd8, x.halted, x.pend, x.mis};
                checks++;
                if (act !== req) begin
                    failures++;
                    $display("FAIL %s: got pc=%h pc4=%h pc8=%h halted=%b pend=%b mis=%b; want pc=%h pc4=%h pc8=%h halted=%b pend=%b mis=%b",
                             x.name, o_pc, o_pc_4, o_pc_8, o_halted, o_pend, o_mis,
                             req[98:67], req[66:35], req[34:3], x.halted, x.pend, x.mis);
                end
            end
        end
    end

    initial begin
        //   rst  en  sm  st  sl  rd  rpc           h     epc           eh  ep  em
        cyc(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h0,       1'b0,1'b0,1'b0,"reset");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h4,       1'b0,1'b0,1'b0,"seq1");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h8,       1'b0,1'b0,1'b0,"seq2");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'hC,       1'b0,1'b0,1'b0,"seq3");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h10,      1'b0,1'b0,1'b0,"seq4");
        // stall with redirect captured mid-stall
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,       1'b0, 32'h10,      1'b0,1'b0,1'b0,"stall1");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,32'h100,     1'b0, 32'h10,      1'b0,1'b1,1'b0,"stall_capture");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,       1'b0, 32'h10,      1'b0,1'b1,1'b0,"stall3");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h100,     1'b0,1'b0,1'b0,"pending_apply");
        // live redirect beats pending
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,32'h100,     1'b0, 32'h100,     1'b0,1'b1,1'b0,"pend_again");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,32'h200,     1'b0, 32'h200,     1'b0,1'b0,1'b0,"live_over_pend");
        // newer pending overwrites older; enable low also holds
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h300,     1'b0, 32'h200,     1'b0,1'b1,1'b0,"cap_300");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,32'h400,     1'b0, 32'h200,     1'b0,1'b1,1'b0,"cap_400");
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h200,     1'b0,1'b1,1'b0,"hold_idle");
        cyc(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0, 32'h400,     1'b0,1'b0,1'b0,"overwrite_apply");
        // reset mid-stall with pending, then step mode
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,32'h500,     1'b0, 32'h400,     1'b0,1'b1,1'b0,"pend_before_rst");
        cyc(1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,       1'b0, 32'h0,       1'b0,1'b0,1'b0,"reset_mid_stall");
        cyc(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h0,       1'b0,1'b0,1'b0,"step_idle1");
        cyc(1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,       1'b0, 32'h4,       1'b0,1'b0,1'b0,"step_pulse1");
        cyc(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h4,       1'b0,1'b0,1'b0,"step_idle2");
        cyc(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h4,       1'b0,1'b0,1'b0,"step_idle3");
        cyc(1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,       1'b0, 32'h8,       1'b0,1'b0,1'b0,"step_pulse2");
        cyc(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h8,       1'b0,1'b0,1'b0,"step_idle4");
        cyc(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,       1'b0, 32'hC,       1'b0,1'b0,1'b0,"step_en_ignored");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h10,      1'b0,1'b0,1'b0,"mode_switch");
        cyc(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0, 32'h10,      1'b0,1'b0,1'b0,"step_ignored_run");
        // halt
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,32'h20,      1'b0, 32'h20,      1'b0,1'b0,1'b0,"to_20");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b1, 32'h20,      1'b1,1'b0,1'b0,"halt");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,32'h500,     1'b0, 32'h20,      1'b1,1'b0,1'b0,"halted_redir");
        cyc(1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,32'h600,     1'b0, 32'h20,      1'b1,1'b0,1'b0,"halted_step");
        cyc(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h0,       1'b0,1'b0,1'b0,"halt_reset");
        // halt clears pending
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,32'h40,      1'b0, 32'h0,       1'b0,1'b1,1'b0,"pend_40");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,32'h80,      1'b1, 32'h0,       1'b1,1'b0,1'b0,"halt_clr_pend");
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h0,       1'b0,1'b0,1'b0,"reset2");
        // wrap and alignment
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,32'hFFFFFFFC,1'b0, 32'hFFFFFFFC,1'b0,1'b0,1'b0,"to_top");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h0,       1'b0,1'b0,1'b0,"wrap");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,32'h103,     1'b0, ALN ? 32'h100 : 32'h103, 1'b0,1'b0,ALN,"mis_live");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, ALN ? 32'h104 : 32'h107, 1'b0,1'b0,ALN,"mis_sticky");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,32'h206,     1'b0, ALN ? 32'h104 : 32'h107, 1'b0,1'b1,ALN,"mis_buf");
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, ALN ? 32'h204 : 32'h206, 1'b0,1'b0,ALN,"mis_buf_apply");
        cyc(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0, 32'h0,       1'b0,1'b0,1'b0,"mis_reset");
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
